// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: configurable frame count/length, data pattern,
// inter-frame gap and graceful stop, with full backpressure support.
module axis_frame_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [31:0] LFSR_SEED  = 32'h1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [CNT_WIDTH-1:0]  num_frames,
  input  logic [LEN_WIDTH-1:0]  gap,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam int unsigned HALF_WIDTH = DATA_WIDTH / 2;
  localparam int unsigned LFSR_REPS  = DATA_WIDTH / 32;
  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // One step of the right-shifting Galois LFSR (taps 32,22,2,1).
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

  // Beat payload for the selected pattern.
  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [1:0]            m,
    input logic [LEN_WIDTH-1:0]  b,
    input logic [DATA_WIDTH-1:0] g,
    input logic [31:0]           l,
    input logic [CNT_WIDTH-1:0]  f
  );
    logic [DATA_WIDTH-1:0] r;
    case (m)
      2'd0:    r = DATA_WIDTH'(b);
      2'd1:    r = g;
      2'd2:    r = {LFSR_REPS{l}};
      default: r = {HALF_WIDTH'(f), HALF_WIDTH'(b)};
    endcase
    return r;
  endfunction

  state_e                state_q;
  logic [1:0]            mode_q;
  logic [LEN_WIDTH-1:0]  last_idx_q;   // L-1, L = max(frame_len, 1)
  logic [CNT_WIDTH-1:0]  num_q;
  logic [LEN_WIDTH-1:0]  gap_q;
  logic [LEN_WIDTH-1:0]  gap_cnt_q;
  logic [LEN_WIDTH-1:0]  beat_idx_q;   // index of the beat on the output
  logic [DATA_WIDTH-1:0] gbeat_q;      // global index of the beat on the output
  logic [31:0]           lfsr_q;       // LFSR word of the beat on the output
  logic                  stop_q;
  logic [CNT_WIDTH-1:0]  frame_cnt_q;  // also the frame index of the current beat
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  tuser_q;
  logic                  busy_q;
  logic                  done_q;

  logic [LEN_WIDTH-1:0]  beat_idx_d;
  logic [DATA_WIDTH-1:0] gbeat_d;
  logic [31:0]           lfsr_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  last_d;
  logic                  user_d;
  logic                  accept_c;
  logic                  stop_seen_c;
  logic                  more_frames_c;

  // Successor beat state, used when the current beat is accepted.
  always_comb begin
    beat_idx_d  = beat_idx_q + LEN_WIDTH'(1);
    frame_cnt_d = frame_cnt_q;
    if (tlast_q) begin
      beat_idx_d  = '0;
      frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
    end
    gbeat_d       = gbeat_q + DATA_WIDTH'(1);
    lfsr_d        = lfsr_step(lfsr_q);
    data_d        = pattern(mode_q, beat_idx_d, gbeat_d, lfsr_d, frame_cnt_d);
    last_d        = (beat_idx_d == last_idx_q);
    user_d        = (beat_idx_d == '0);
    accept_c      = tvalid_q && m_axis_tready;
    stop_seen_c   = stop_q || stop;
    more_frames_c = (num_q == '0) || (frame_cnt_d != num_q);
  end

  // Run-control FSM with registered stream and status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      last_idx_q  <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      beat_idx_q  <= '0;
      gbeat_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      stop_q      <= 1'b0;
      frame_cnt_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_RUN;
            mode_q      <= mode;
            last_idx_q  <= (frame_len == '0) ? '0 : frame_len - LEN_WIDTH'(1);
            num_q       <= num_frames;
            gap_q       <= gap;
            beat_idx_q  <= '0;
            gbeat_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            stop_q      <= 1'b0;
            frame_cnt_q <= '0;
            tdata_q     <= pattern(mode, '0, '0, LFSR_SEED, '0);
            tvalid_q    <= 1'b1;
            tuser_q     <= 1'b1;
            tlast_q     <= (frame_len <= LEN_WIDTH'(1));
            busy_q      <= 1'b1;
          end
        end

        S_RUN: begin
          stop_q <= stop_seen_c;
          if (accept_c) begin
            beat_idx_q  <= beat_idx_d;
            gbeat_q     <= gbeat_d;
            lfsr_q      <= lfsr_d;
            frame_cnt_q <= frame_cnt_d;
            if (tlast_q && (stop_seen_c || !more_frames_c)) begin
              // Frame finished and the run is over.
              state_q  <= S_IDLE;
              stop_q   <= 1'b0;
              tdata_q  <= '0;
              tvalid_q <= 1'b0;
              tuser_q  <= 1'b0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else if (tlast_q && (gap_q != '0)) begin
              // Next frame is already prepared; park it until the gap elapses.
              state_q   <= S_GAP;
              gap_cnt_q <= gap_q - LEN_WIDTH'(1);
              tvalid_q  <= 1'b0;
              tuser_q   <= 1'b0;
              tlast_q   <= 1'b0;
            end else begin
              tdata_q <= data_d;
              tuser_q <= user_d;
              tlast_q <= last_d;
            end
          end
        end

        S_GAP: begin
          stop_q <= stop_seen_c;
          if (stop_seen_c) begin
            state_q <= S_IDLE;
            stop_q  <= 1'b0;
            tdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_cnt_q == '0) begin
            state_q  <= S_RUN;
            tdata_q  <= pattern(mode_q, beat_idx_q, gbeat_q, lfsr_q, frame_cnt_q);
            tvalid_q <= 1'b1;
            tuser_q  <= 1'b1;
            tlast_q  <= (last_idx_q == '0);
          end else begin
            gap_cnt_q <= gap_cnt_q - LEN_WIDTH'(1);
          end
        end

        default: begin
          state_q  <= S_IDLE;
          tvalid_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

Parametrised AXI4-Stream frame generator that replaces the fixed-pattern stimulus source feeding the windowing/multiply pipeline. It emits a configurable number of frames of configurable length, with a selectable data pattern, an optional inter-frame gap and a controlled stop. It honours full AXI4-Stream backpressure and marks start-of-frame (tuser) and end-of-frame (tlast). It sits upstream of any AXIS slave, both in simulation benches and as an on-chip traffic source.

## Interface
Parameters:
- DATA_WIDTH, 64: tdata width; must be a multiple of 32, minimum 32.
- LEN_WIDTH, 16: width of frame_len, beat counter and gap counter.
- CNT_WIDTH, 16: width of num_frames and frame_cnt.
- LFSR_SEED, 32'h1: initial LFSR value; must be nonzero.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  request end of run after the current frame completes.
- mode  in  2  data pattern; latched at start.
- frame_len  in  LEN_WIDTH  beats per frame; latched at start.
- num_frames  in  CNT_WIDTH  frames per run; 0 means unbounded. Latched at start.
- gap  in  LEN_WIDTH  idle cycles between frames; latched at start.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tuser  out  1  first beat of frame (SOF).
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when a run ends.
- frame_cnt  out  CNT_WIDTH  count of frames fully accepted in the current or last run.

## Operation
- States:
  - IDLE → RUN on start. At the same time: latch config, clear beat_idx, clear frame_cnt, set frame_idx to 0.
  - RUN → GAP when the last beat is accepted, gap > 0, and more frames remain.
  - RUN → RUN (next frame, back-to-back) on the same condition with gap = 0.
  - RUN → IDLE when the last beat is accepted and no frames remain, or when stop was seen. Pulse done on this transition.
  - GAP → RUN after gap cycles have elapsed.
- Accept means m_axis_tvalid && m_axis_tready.
- Effective length is L = max(frame_len, 1).
- Data patterns, per beat:
  - mode 0: beat_idx, zero-extended.
  - mode 1: global beat counter, continuing across frames.
  - mode 2: 32-bit Galois LFSR (taps 32,22,2,1; mask 32'h80200003), replicated across DATA_WIDTH. The LFSR steps once per accepted beat. It reloads LFSR_SEED at start.
  - mode 3: frame_idx in the upper half, beat_idx in the lower half, each truncated or zero-extended to DATA_WIDTH/2.
- Flags:
  - tuser = 1 exactly on beat_idx 0.
  - tlast = 1 exactly on beat_idx L-1.
  - When L = 1, tuser and tlast are both high on the same beat.
- Counters:
  - frame_cnt increments on each accepted tlast.
  - frame_cnt and frame_idx wrap modulo 2^CNT_WIDTH.
  - With num_frames = 0, wrap does not end the run.
- stop is sticky once seen in RUN or GAP, and is cleared on entering IDLE.
  - In RUN: the current frame completes fully; no truncated frame is ever emitted.
  - In GAP: go to IDLE on the next cycle, with the done pulse.
- start while busy is ignored. If start and stop are both high in IDLE, start wins; stop is then seen on the next cycle and yields exactly one frame.
- Config inputs are ignored while busy.

## Timing
- All outputs are registered.
- Reset values: tdata 0, tvalid 0, tlast 0, tuser 0, busy 0, done 0, frame_cnt 0. The LFSR resets to LFSR_SEED.
- Reset mid-run clears all of the above immediately (asynchronously) and returns the block to IDLE. No done pulse is produced.
- Start latency: start high at edge N in IDLE gives busy = 1 and tvalid = 1 with beat 0 on the output from edge N+1.
- Backpressure: while tvalid && !tready, tdata, tlast and tuser hold stable. tvalid never drops without an accept.
- Throughput: with tready held at 1, one beat is accepted per cycle.
- Frame boundary with gap = 0: beat 0 of the next frame follows the accepted tlast with no bubble.
- Frame boundary with gap = G > 0: tvalid is low for exactly G cycles after the cycle in which tlast is accepted.
- End of run:
  - tvalid falls the cycle after the final tlast is accepted.
  - done pulses in that same cycle.
  - busy falls in that same cycle.
- A new start is accepted on the cycle after done.

## Test plan
- Basic run: mode 0, frame_len 4, num_frames 2, gap 0, tready = 1 → 8 consecutive beats with data 0,1,2,3,0,1,2,3. tuser is high on beats 0 and 4; tlast on beats 3 and 7. done pulses one cycle after beat 7; frame_cnt = 2.
- Backpressure and global counter: mode 1, frame_len 5, num_frames 1, with tready toggling 1,0,0,1,… → tdata, tuser and tlast are stable during every stall. Accepted data is 0..4 with no loss or duplication.
- Gap, LFSR and single-beat frames: mode 2, gap 3, frame_len 1, num_frames 3 → exactly 3 idle cycles between frames. tuser = tlast = 1 on every beat. The first three words match the LFSR sequence from seed 1, replicated in both 32-bit halves.
- Stop mid-frame: mode 3, frame_len 8, num_frames 0; assert stop during beat 2 of frame 5 → frame 5 completes through beat 7, tdata = {5,7} on the last beat. Then done, frame_cnt = 6, and no further tvalid.
- Reset and restart: assert resetn low while tvalid is high with tready = 0 → all outputs are 0 immediately. After release, start gives beat 0 one cycle later and frame_cnt counts from 0.
- Edge cases, two runs:
  - Run 1: frame_len 0, num_frames 1 → exactly one beat, with tuser = tlast = 1.
  - Run 2: start pulsed while busy during run 1 has no effect.
